// File: rtl/risc_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : risc_dmem_arbiter
// Brief    : Two-requester round-robin arbiter and single-access sequencer
//            for the RISC-V core data memory. A = core load/store path,
//            B = DMA/debug loader. One access per transaction; out-of-range
//            word addresses are answered with err=1 without touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module risc_dmem_arbiter #(
    parameter int DEPTH_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,

    output logic        err,
    output logic        busy,

    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Requester identifiers used for r_id and r_last_grant
    localparam logic c_ID_A = 1'b0;
    localparam logic c_ID_B = 1'b1;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_id;
    logic        r_we;
    logic        r_range_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_mem_we;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;
    logic        r_err;
    logic        r_busy;

    logic        w_any_req;
    logic        w_pick_b;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_range_err;
    logic [31:0] w_rd_capture;

    // Winner select: a lone requester wins, a tie goes to whoever was not granted last
    always_comb begin
        w_any_req       = a_req | b_req;
        w_pick_b        = b_req & (~a_req | (r_last_grant == c_ID_A));
        w_sel_we        = w_pick_b ? b_we    : a_we;
        w_sel_addr      = w_pick_b ? b_addr  : a_addr;
        w_sel_wdata     = w_pick_b ? b_wdata : a_wdata;
        w_sel_range_err = |w_sel_addr[31:DEPTH_BITS];
        // Only an in-range read returns memory data; writes and rejects return zero
        w_rd_capture    = (!r_we && !r_range_err) ? mem_rdata : 32'd0;
    end

    // Transaction sequencer: IDLE latches a winner, ACCESS drives memory, RESP acknowledges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_ID_B;
            r_id         <= c_ID_A;
            r_we         <= 1'b0;
            r_range_err  <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_mem_we     <= 1'b0;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_a_rdata    <= 32'd0;
            r_b_rdata    <= 32'd0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ST_ACCESS;
                        r_id         <= w_pick_b;
                        r_last_grant <= w_pick_b;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_range_err  <= w_sel_range_err;
                        // Write strobe is high for exactly the ACCESS cycle, never for a reject
                        r_mem_we     <= w_sel_we & ~w_sel_range_err;
                        r_busy       <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_state   <= ST_RESP;
                    r_mem_we  <= 1'b0;
                    r_err     <= r_range_err;
                    r_a_ack   <= (r_id == c_ID_A);
                    r_b_ack   <= (r_id == c_ID_B);
                    r_a_rdata <= (r_id == c_ID_A) ? w_rd_capture : 32'd0;
                    r_b_rdata <= (r_id == c_ID_B) ? w_rd_capture : 32'd0;
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_a_ack   <= 1'b0;
                    r_b_ack   <= 1'b0;
                    r_a_rdata <= 32'd0;
                    r_b_rdata <= 32'd0;
                    r_err     <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign a_ack     = r_a_ack;
    assign a_rdata   = r_a_rdata;
    assign b_ack     = r_b_ack;
    assign b_rdata   = r_b_rdata;
    assign err       = r_err;
    assign busy      = r_busy;
    assign mem_addr  = r_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_risc_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_dmem_arbiter
// Brief    : Scoreboard bench for risc_dmem_arbiter. Requester drivers push
//            issued transactions into per-requester queues; a negedge monitor
//            pops them on each ack and checks against a word-array memory
//            model, the memory-bus activity of the ACCESS cycle, latency and
//            round-robin fairness.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          issue;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, a_ack;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_ack;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        err, busy, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    risc_dmem_arbiter #(.DEPTH_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .err(err), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        mem_init;
    logic        exact_lat = 1'b1;
    logic        log_en = 1'b0;
    logic        last_id = 1'b1;
    int          n_writes_seen = 0;
    int          n_writes_exp = 0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    txn_t        qa[$];
    txn_t        qb[$];
    int          log_cyc[$];
    logic        log_id[$];
    logic [31:0] phys_mem [0:63];
    logic [31:0] ref_mem  [0:63];

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory attached to the arbiter: combinational read, write on rising edge
    assign mem_rdata = phys_mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) phys_mem[i] <= init_word(i);
        end else if (mem_we) begin
            phys_mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pop the acknowledged transaction and check the response against the model
    task automatic score(input logic id);
        txn_t        t;
        logic        e_err;
        logic [31:0] e_rd;
        int          lat;
        logic        oth_pend;
        int          depth;
        depth = (id == 1'b0) ? qa.size() : qb.size();
        cmp(id ? "b_ack_has_request" : "a_ack_has_request", 32'(depth > 0), 32'd1);
        if (depth == 0) return;
        if (id == 1'b0) t = qa.pop_front();
        else            t = qb.pop_front();
        e_err = |t.addr[31:6];
        e_rd  = (t.we || e_err) ? 32'd0 : ref_mem[t.addr[5:0]];
        if (t.we && !e_err) begin
            ref_mem[t.addr[5:0]] = t.wdata;
            n_writes_exp++;
        end
        cmp("err", 32'(err), 32'(e_err));
        cmp("rdata", id ? b_rdata : a_rdata, e_rd);
        cmp("other_rdata", id ? a_rdata : b_rdata, 32'd0);
        cmp("busy_in_resp", 32'(busy), 32'd1);
        cmp("access_mem_we", 32'(p_we), 32'(t.we && !e_err));
        cmp("access_mem_addr", p_addr, t.addr);
        if (t.we) cmp("access_mem_wdata", p_wdata, t.wdata);
        lat = cyc - t.issue;
        if (exact_lat) cmp("latency", 32'(lat), 32'd2);
        else           cmp("latency_2_to_5", 32'(lat >= 2 && lat <= 5), 32'd1);
        if (id == 1'b0) oth_pend = (qb.size() > 0) && (qb[0].issue <= cyc - 2);
        else            oth_pend = (qa.size() > 0) && (qa[0].issue <= cyc - 2);
        if (oth_pend) cmp("round_robin_not_same_twice", 32'(id != last_id), 32'd1);
        last_id = id;
        if (log_en) begin
            log_cyc.push_back(cyc);
            log_id.push_back(id);
        end
    endtask

    // Monitor: checks every ack and tracks the memory bus of the previous cycle
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        end else if (rst) begin
            last_id = 1'b1;
        end else begin
            if (a_ack && b_ack) cmp("single_ack", 32'(a_ack & b_ack), 32'd0);
            if (a_ack) score(1'b0);
            if (b_ack) score(1'b1);
            if (mem_we) n_writes_seen++;
            p_we    = mem_we;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
        end
    end

    // Issue one transaction, hold it until ack, return one cycle after the ack cycle
    task automatic drive(input logic id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        txn_t t;
        int   n;
        t.we = we; t.addr = addr; t.wdata = wdata; t.issue = cyc;
        if (id == 1'b0) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
            qa.push_back(t);
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
            qb.push_back(t);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? b_ack : a_ack) && n < 12);
        if (!(id ? b_ack : a_ack)) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: requester %0d saw no ack after %0d cycles, expected within 5", id, n);
            if (id == 1'b0) qa.delete();
            else            qb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_req(input logic id);
        if (id == 1'b0) a_req = 1'b0;
        else            b_req = 1'b0;
    endtask

    task automatic rand_driver(input logic id, input int n);
        logic        we;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'd64 + $urandom_range(0, 3);
                default: addr = $urandom_range(0, 7);
            endcase
            drive(id, we, addr, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                release_req(id);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        release_req(id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nmis;
        rst = 1'b1; mem_init = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mem_init = 1'b0;

        cmp("reset_ctrl_outputs", {27'd0, a_ack, b_ack, err, busy, mem_we}, 32'd0);
        cmp("reset_a_rdata", a_rdata, 32'd0);
        cmp("reset_b_rdata", b_rdata, 32'd0);
        cmp("reset_mem_addr", mem_addr, 32'd0);
        cmp("reset_mem_wdata", mem_wdata, 32'd0);

        // Directed single-requester traffic
        exact_lat = 1'b1;
        drive(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);   release_req(1'b0);
        drive(1'b0, 1'b0, 32'd5, 32'd0);           release_req(1'b0);
        drive(1'b1, 1'b1, 32'h40, 32'h1234_5678);  release_req(1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0);           release_req(1'b0);
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);   release_req(1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Both requesters hold req continuously; last grant was B so A leads
        exact_lat = 1'b0;
        log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'd1, 32'h11);
                release_req(1'b0);
            end
            begin
                for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'd2, 32'h22);
                release_req(1'b1);
            end
        join
        log_en = 1'b0;
        cmp("contention_ack_count", 32'(log_id.size()), 32'd6);
        for (int i = 0; i < log_id.size(); i++) begin
            cmp("contention_grant_order", 32'(log_id[i]), 32'(i % 2));
            if (i > 0) cmp("contention_ack_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset during ACCESS of an A read: transaction is dropped
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
        @(posedge clk);
        #2;
        cmp("in_access_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        cmp("midreset_ctrl_outputs", {27'd0, a_ack, b_ack, err, busy, mem_we}, 32'd0);
        cmp("midreset_rdata", a_rdata | b_rdata, 32'd0);
        cmp("midreset_mem_addr", mem_addr, 32'd0);
        cmp("midreset_mem_wdata", mem_wdata, 32'd0);
        a_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        cmp("dropped_txn_no_ack_seen", 32'(qa.size()), 32'd0);
        @(posedge clk);
        #1;
        exact_lat = 1'b1;
        drive(1'b0, 1'b0, 32'd5, 32'd0);
        release_req(1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Randomised contention between both requesters
        exact_lat = 1'b0;
        fork
            rand_driver(1'b0, 80);
            rand_driver(1'b1, 80);
        join
        repeat (6) @(posedge clk);
        #1;

        cmp("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
        cmp("write_strobe_count", 32'(n_writes_seen), 32'(n_writes_exp));
        nmis = 0;
        for (int i = 0; i < 64; i++) if (phys_mem[i] !== ref_mem[i]) nmis++;
        cmp("memory_image_mismatches", 32'(nmis), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
